// File: rtl/mem_bus_ctrl.sv
// Registered memory bus controller: latches address/data on a request, runs one
// read or write with a ready handshake, then pulses done. MEM_TIMEOUT_EN adds an abort timer.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata_out,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        timeout;
  logic        busy_nxt, done_nxt, err_nxt, read_nxt, write_nxt;
  logic [15:0] rdata_nxt, addr_nxt, wdata_nxt;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("mem_bus_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  assign accept = (state == IDLE) && (rd_req || wr_req);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt;
  logic [7:0] cnt_inc;

  assign cnt_inc = cnt + 8'd1;
  // Abort on the edge that would complete the TIMEOUT_CYCLES-th unanswered ACCESS cycle.
  assign timeout = (state == ACCESS) && !mem_ready && (cnt_inc == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt <= 8'd0;
    else if (accept)                       cnt <= 8'd0;
    else if (state == ACCESS && !mem_ready) cnt <= cnt_inc;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_req || wr_req)      state_nxt = ACCESS;
      ACCESS:  if (mem_ready || timeout)  state_nxt = DONE;
      DONE:                               state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    rdata_nxt = rdata_out;
    err_nxt   = err;
    read_nxt  = 1'b0;
    write_nxt = 1'b0;
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == DONE);
    case (state)
      IDLE: begin
        if (accept) begin
          addr_nxt  = addr_in;
          wdata_nxt = wdata_in;
          err_nxt   = 1'b0;
          write_nxt = wr_req;
          read_nxt  = !wr_req;
        end
      end
      ACCESS: begin
        // Ready takes priority over a timeout landing on the same edge.
        if (mem_ready) begin
          if (mem_read) rdata_nxt = mem_rdata;
        end else if (timeout) begin
          err_nxt = 1'b1;
        end else begin
          read_nxt  = mem_read;
          write_nxt = mem_write;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rdata_out <= 16'h0000;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
    end else begin
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      mem_read  <= read_nxt;
      mem_write <= write_nxt;
      rdata_out <= rdata_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: a memory model answers strobes after a set
// number of wait states; a monitor checks each done pulse against queued expectations.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_in = 16'h0, wdata_in = 16'h0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic        busy, done, err, mem_read, mem_write;
  logic [15:0] rdata_out, mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'hDEAD;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .wdata_in(wdata_in),
    .rd_req(rd_req), .wr_req(wr_req), .busy(busy), .done(done), .err(err),
    .rdata_out(rdata_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          cycles;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model state
  int          wait_states = 0;
  logic [15:0] rd_word = 16'h0;
  bit          ready_in_idle = 1'b0;
  int          strobe_cycles = 0;
  logic        cap_wr = 1'b0, last_wr = 1'b0;
  logic [15:0] cap_addr = 16'h0, cap_wdata = 16'h0, last_addr = 16'h0, last_wdata = 16'h0;
  int          last_cycles = 0;

  // Memory responder followed by the done monitor, in one process so the
  // strobe summary is always updated before a done pulse is scored.
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      if (strobe_cycles == 0) begin
        cap_wr    = mem_write;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
      end else begin
        check("addr_stable", mem_addr, cap_addr);
        check("wdata_stable", mem_wdata, cap_wdata);
        check("strobe_kind_stable", mem_write, cap_wr);
      end
      check("single_strobe", mem_read & mem_write, 0);
      strobe_cycles++;
      mem_ready = (strobe_cycles > wait_states);
      mem_rdata = mem_ready ? rd_word : 16'hDEAD;
    end else begin
      if (strobe_cycles != 0) begin
        last_wr     = cap_wr;
        last_addr   = cap_addr;
        last_wdata  = cap_wdata;
        last_cycles = strobe_cycles;
      end
      strobe_cycles = 0;
      mem_ready     = ready_in_idle;
      mem_rdata     = 16'hDEAD;
    end

    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending transaction");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("txn_kind", last_wr, e.wr);
        check("txn_addr", last_addr, e.addr);
        if (e.wr) check("txn_wdata", last_wdata, e.wdata);
        check("strobe_cycles", last_cycles, e.cycles);
        check("done_rdata", rdata_out, e.rdata);
        check("done_err", err, e.err);
        check("done_busy", busy, 1);
        check("done_strobes_low", {mem_read, mem_write}, 0);
      end
    end
  end

  task automatic expect_txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                            input int cycles, input logic [15:0] rd, input logic e);
    exp_t x;
    x.wr = wr; x.addr = a; x.wdata = d; x.cycles = cycles; x.rdata = rd; x.err = e;
    sb.push_back(x);
  endtask

  // Called #1 after a rising edge; the request is sampled at the next edge.
  task automatic start(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input int waits, input logic [15:0] word);
    wait_states = waits;
    rd_word     = word;
    rd_req = rd; wr_req = wr; addr_in = a; wdata_in = d;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0; addr_in = 16'h0; wdata_in = 16'h0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got busy stuck high expected return to idle within 200 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read: done and data one edge after the access starts
    expect_txn(1'b0, 16'h1234, 16'h0, 1, 16'hBEEF, 1'b0);
    start(1'b1, 1'b0, 16'h1234, 16'h0, 0, 16'hBEEF);
    check("zw_mem_read", mem_read, 1);
    check("zw_mem_addr", mem_addr, 16'h1234);
    @(posedge clk); #1;
    check("zw_done", done, 1);
    check("zw_rdata", rdata_out, 16'hBEEF);
    check("zw_strobe_low", mem_read, 0);
    @(posedge clk); #1;
    check("zw_idle_busy", busy, 0);
    check("zw_idle_done", done, 0);

    // Write with 3 wait states: four strobe cycles, rdata untouched
    expect_txn(1'b1, 16'h00FF, 16'hA5A5, 4, 16'hBEEF, 1'b0);
    start(1'b0, 1'b1, 16'h00FF, 16'hA5A5, 3, 16'h1357);
    check("wr_mem_write", mem_write, 1);
    check("wr_mem_wdata", mem_wdata, 16'hA5A5);
    wait_idle("wr_wait_idle");
    check("wr_rdata_kept", rdata_out, 16'hBEEF);

    // Simultaneous requests: write wins; a read held through busy is ignored
    expect_txn(1'b1, 16'h0042, 16'h1111, 2, 16'hBEEF, 1'b0);
    start(1'b1, 1'b1, 16'h0042, 16'h1111, 1, 16'h2468);
    check("both_write_wins", {mem_write, mem_read}, 2'b10);
    rd_req = 1'b1; addr_in = 16'h0099;
    repeat (3) @(posedge clk);
    #1;
    rd_req = 1'b0; addr_in = 16'h0;
    check("busy_req_idle", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("busy_req_dropped", {busy, mem_read}, 0);
    check("sb_empty_after_both", sb.size(), 0);

    // mem_ready while idle is ignored
    ready_in_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_busy", busy, 0);
    check("idle_ready_done", done, 0);
    ready_in_idle = 1'b0;
    @(posedge clk); #1;

    // Read with 2 wait states
    expect_txn(1'b0, 16'h0300, 16'h0, 3, 16'h5A5A, 1'b0);
    start(1'b1, 1'b0, 16'h0300, 16'h0, 2, 16'h5A5A);
    wait_idle("rd2_wait_idle");
    check("rd2_rdata", rdata_out, 16'h5A5A);

    // Asynchronous reset in the middle of an access
    start(1'b1, 1'b0, 16'h0777, 16'h0, 1000, 16'hFFFF);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_read", mem_read, 0);
    check("arst_busy", busy, 0);
    check("arst_rdata", rdata_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_txn(1'b0, 16'h0ABC, 16'h0, 1, 16'hCAFE, 1'b0);
    start(1'b1, 1'b0, 16'h0ABC, 16'h0, 0, 16'hCAFE);
    wait_idle("post_rst_wait_idle");
    check("post_rst_rdata", rdata_out, 16'hCAFE);

`ifdef MEM_TIMEOUT_EN
    // Timeout after 4 unanswered access cycles; err sticks until next request
    expect_txn(1'b0, 16'h0555, 16'h0, 4, 16'hCAFE, 1'b1);
    start(1'b1, 1'b0, 16'h0555, 16'h0, 1000, 16'h1111);
    wait_idle("to_wait_idle");
    check("to_err_held", err, 1);
    check("to_rdata_kept", rdata_out, 16'hCAFE);
    repeat (2) @(posedge clk);
    #1;
    check("to_err_still_held", err, 1);
    expect_txn(1'b1, 16'h0666, 16'h7777, 1, 16'hCAFE, 1'b0);
    start(1'b0, 1'b1, 16'h0666, 16'h7777, 0, 16'h0);
    check("to_err_cleared", err, 0);
    wait_idle("to_next_wait_idle");
`else
    // Without the timer a slow memory simply stretches the access
    expect_txn(1'b0, 16'h0555, 16'h0, 21, 16'h1111, 1'b0);
    start(1'b1, 1'b0, 16'h0555, 16'h0, 20, 16'h1111);
    repeat (15) @(posedge clk);
    #1;
    check("nto_strobe_held", mem_read, 1);
    check("nto_err_zero", err, 0);
    check("nto_busy", busy, 1);
    wait_idle("nto_wait_idle");
    check("nto_rdata", rdata_out, 16'h1111);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
